sum_a_b_accum_stage: RTL and testbench

User-fabric stage that computes a+b from two Simulink data inputs and drives the 32-bit user_data_in of the sum_a_b simulink2ppc software register.
- Two-stage pipeline with instantaneous or accumulate mode, sample counter and sticky overflow flag.
- Freeze control holds the output word stable while software reads it over OPB, so the register never samples a mid-update value.
- Sits directly upstream of the register, in the user_clk domain.

---
 rtl/sum_a_b_accum_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_sum_a_b_accum_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_a_b_accum_stage.sv
// ---------------------------------------------------------------------------
// sum_a_b_accum_stage
//
// User-fabric stage that forms a + b from two unsigned data inputs and drives
// the 32-bit user_data_in of the sum_a_b simulink2ppc software register.
// Lives entirely in the user_clk domain, directly upstream of the register.
//
// Pipeline:
//   stage 1 : sum1 <= zero_ext(a_in) + zero_ext(b_in)   (captured on in_valid)
//             v1   <= in_valid
//   stage 2 : when v1 is set, acc takes sum1 (mode=0) or acc + sum1 (mode=1),
//             the sample counter advances and the output FSM may publish acc.
//   Inputs driven after edge N appear on user_data_out / out_valid after N+2.
//   Full throughput, no backpressure.
//
// Handshake: in_valid qualifies a_in/b_in for exactly the cycle it is high;
// there is no ready, every valid sample is taken. out_valid is a one-cycle
// pulse that marks the cycle user_data_out carries a freshly published word.
//
// Output FSM (visible on out_state):
//   IDLE   (2'd0) : after reset/clr, output 0. First stage-2 sample -> RUN.
//   RUN    (2'd1) : every stage-2 sample publishes acc with an out_valid pulse.
//                   freeze=1 -> FROZEN (freeze beats a same-cycle sample).
//   FROZEN (2'd2) : output held, out_valid low; acc/count/ovf keep running.
//                   freeze=0 -> RUN; the output refreshes on the next sample.
//
// Parameters:
//   A_WIDTH   : width of unsigned operand a_in
//   B_WIDTH   : width of unsigned operand b_in
//               (max(A_WIDTH, B_WIDTH) + 1 must not exceed 32)
//   CNT_WIDTH : width of the saturating sample counter
//
// Ports:
//   user_clk      in   sole clock
//   user_rst_n    in   synchronous active-low reset, overrides everything
//   a_in          in   operand a (A_WIDTH)
//   b_in          in   operand b (B_WIDTH)
//   in_valid      in   a_in/b_in valid this cycle
//   mode          in   0 = instantaneous sum, 1 = accumulate (sampled in stage 2)
//   clr           in   synchronous clear of acc, counter, ovf, output, FSM
//   freeze        in   hold user_data_out while high
//   user_data_out out  32-bit word to the register's user_data_in
//   out_valid     out  one-cycle pulse when user_data_out updates
//   sample_cnt    out  accepted samples since reset/clr, saturating at all-ones
//   ovf           out  sticky overflow flag (accumulate carry out of bit 31)
//   out_state     out  debug view of the output FSM state
//
// Build option:
//   SUM_A_B_SATURATE_EN : when defined, an accumulate that would exceed
//   0xFFFFFFFF loads 0xFFFFFFFF instead of wrapping. Default (undefined):
//   the accumulator wraps modulo 2^32. ovf is set on carry either way.
// ---------------------------------------------------------------------------
module sum_a_b_accum_stage #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 user_clk,
  input  logic                 user_rst_n,
  input  logic [A_WIDTH-1:0]   a_in,
  input  logic [B_WIDTH-1:0]   b_in,
  input  logic                 in_valid,
  input  logic                 mode,
  input  logic                 clr,
  input  logic                 freeze,
  output logic [31:0]          user_data_out,
  output logic                 out_valid,
  output logic [CNT_WIDTH-1:0] sample_cnt,
  output logic                 ovf,
  output logic [1:0]           out_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [31:0]          sum1;
  logic                 v1;
  logic [31:0]          acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf_q;
  logic [1:0]           state;
  logic [31:0]          data_q;
  logic                 valid_q;

  // -------------------------------------------------------------------------
  // Stage 1: operand add
  // The true result width is max(A,B)+1 <= 32, so doing the add directly at
  // 32 bits on zero-extended operands is exact and already zero-extended.
  // -------------------------------------------------------------------------
  logic [31:0] a_ext;
  logic [31:0] b_ext;
  logic [31:0] sum_in;

  always_comb begin
    a_ext  = 32'(a_in);
    b_ext  = 32'(b_in);
    sum_in = a_ext + b_ext;
  end

  // -------------------------------------------------------------------------
  // Stage 2: accumulator, sample counter and sticky overflow
  // -------------------------------------------------------------------------
  logic [32:0]          acc_add;
  logic [31:0]          acc_nxt;
  logic                 ovf_nxt;
  logic [CNT_WIDTH-1:0] cnt_nxt;

  always_comb begin
    acc_add = {1'b0, acc} + {1'b0, sum1};
    acc_nxt = acc;
    ovf_nxt = ovf_q;
    cnt_nxt = cnt;
    if (v1) begin
      if (mode) begin
        if (acc_add[32]) begin
          ovf_nxt = 1'b1;
`ifdef SUM_A_B_SATURATE_EN
          // Pin at full scale; once pinned every further accumulate carries
          // again, so acc stays at all-ones until clr/reset.
          acc_nxt = 32'hFFFF_FFFF;
`else
          acc_nxt = acc_add[31:0];
`endif
        end else begin
          acc_nxt = acc_add[31:0];
        end
      end else begin
        acc_nxt = sum1;
      end
      if (cnt != {CNT_WIDTH{1'b1}}) begin
        cnt_nxt = cnt + CNT_WIDTH'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output FSM
  // The published word is the post-update acc (acc_nxt), so a sample seen in
  // stage 2 reaches user_data_out on the same edge it reaches acc.
  // -------------------------------------------------------------------------
  logic [1:0]  state_nxt;
  logic [31:0] data_nxt;
  logic        valid_nxt;

  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    valid_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (v1) begin
          if (freeze) begin
            // Freeze wins over the first sample: acc absorbs it, output
            // stays at 0 until a sample arrives after release.
            state_nxt = ST_FROZEN;
          end else begin
            state_nxt = ST_RUN;
            data_nxt  = acc_nxt;
            valid_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (freeze) begin
          state_nxt = ST_FROZEN;
        end else if (v1) begin
          data_nxt  = acc_nxt;
          valid_nxt = 1'b1;
        end
      end
      ST_FROZEN: begin
        // Release does not republish; the next stage-2 sample will.
        if (!freeze) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers. Reset and clr have identical effect: everything returns to
  // zero/IDLE and any in-flight stage-1 sample is discarded, including one
  // presented in the same cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge user_clk) begin
    if (!user_rst_n || clr) begin
      sum1    <= '0;
      v1      <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      ovf_q   <= 1'b0;
      state   <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (in_valid) begin
        sum1 <= sum_in;
      end
      v1      <= in_valid;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      ovf_q   <= ovf_nxt;
      state   <= state_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
    end
  end

  assign user_data_out = data_q;
  assign out_valid     = valid_q;
  assign sample_cnt    = cnt;
  assign ovf           = ovf_q;
  assign out_state     = state;

endmodule

// File: tb/tb_sum_a_b_accum_stage.sv
// ---------------------------------------------------------------------------
// tb_sum_a_b_accum_stage
//
// Drives sum_a_b_accum_stage (31-bit operands, 4-bit counter so counter
// saturation is reachable) with directed scenarios followed by randomized
// traffic, comparing every cycle against a behavioural model written from
// the block's rules: a queue of pending sums, a wide integer accumulator and
// an idle/run/frozen output state.
// ---------------------------------------------------------------------------
module tb_sum_a_b_accum_stage;

  localparam int A_W = 31;
  localparam int B_W = 31;
  localparam int C_W = 4;
  localparam int CNT_MAX = (1 << C_W) - 1;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  logic           user_rst_n = 1'b0;
  logic [A_W-1:0] a_in       = '0;
  logic [B_W-1:0] b_in       = '0;
  logic           in_valid   = 1'b0;
  logic           mode       = 1'b0;
  logic           clr        = 1'b0;
  logic           freeze     = 1'b0;
  logic [31:0]    user_data_out;
  logic           out_valid;
  logic [C_W-1:0] sample_cnt;
  logic           ovf;
  logic [1:0]     out_state;

  sum_a_b_accum_stage #(
    .A_WIDTH  (A_W),
    .B_WIDTH  (B_W),
    .CNT_WIDTH(C_W)
  ) dut (
    .user_clk     (user_clk),
    .user_rst_n   (user_rst_n),
    .a_in         (a_in),
    .b_in         (b_in),
    .in_valid     (in_valid),
    .mode         (mode),
    .clr          (clr),
    .freeze       (freeze),
    .user_data_out(user_data_out),
    .out_valid    (out_valid),
    .sample_cnt   (sample_cnt),
    .ovf          (ovf),
    .out_state    (out_state)
  );

  // ---------------------------------------------------------------------
  // Scoreboard and reference model
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]     exp_q[$];  // sums accepted but not yet folded into acc
  longint unsigned m_acc   = 0;
  int              m_cnt   = 0;
  bit              m_ovf   = 0;
  logic [31:0]     m_out   = '0;
  bit              m_valid = 0;
  int              m_st    = 0;  // 0 idle, 1 run, 2 frozen

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at it.
  task automatic model_edge();
    bit              has;
    logic [31:0]     s;
    longint unsigned t;
    m_valid = 0;
    if (!user_rst_n || clr) begin
      m_acc = 0;
      m_cnt = 0;
      m_ovf = 0;
      m_out = '0;
      m_st  = 0;
      exp_q.delete();
      return;
    end
    has = (exp_q.size() > 0);
    s   = has ? exp_q.pop_front() : 32'd0;
    if (has) begin
      if (mode) begin
        t = m_acc + longint'(s);
        if (t > 64'hFFFF_FFFF) begin
          m_ovf = 1;
`ifdef SUM_A_B_SATURATE_EN
          t = 64'hFFFF_FFFF;
`else
          t = t - 64'h1_0000_0000;
`endif
        end
        m_acc = t;
      end else begin
        m_acc = longint'(s);
      end
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    if (m_st == 2) begin
      if (!freeze) m_st = 1;
    end else if (freeze && (m_st == 1 || has)) begin
      m_st = 2;
    end else if (has) begin
      m_st    = 1;
      m_out   = m_acc[31:0];
      m_valid = 1;
    end
    if (in_valid) exp_q.push_back(32'(longint'(a_in) + longint'(b_in)));
  endtask

  // ---------------------------------------------------------------------
  // Driver: apply inputs on the falling edge, advance the model on the
  // rising edge, compare everything 1 ns later.
  // ---------------------------------------------------------------------
  task automatic step(input bit rn, input bit iv, input logic [31:0] a, input logic [31:0] b,
                      input bit md, input bit cl, input bit fr);
    @(negedge user_clk);
    user_rst_n = rn;
    in_valid   = iv;
    a_in       = a[A_W-1:0];
    b_in       = b[B_W-1:0];
    mode       = md;
    clr        = cl;
    freeze     = fr;
    @(posedge user_clk);
    model_edge();
    #1;
    check("data",  user_data_out,       m_out);
    check("valid", 32'(out_valid),      32'(m_valid));
    check("cnt",   32'(sample_cnt),     32'(m_cnt));
    check("ovf",   32'(ovf),            32'(m_ovf));
    check("state", 32'(out_state),      32'(m_st));
  endtask

  task automatic idle(input bit md);
    step(1, 0, 0, 0, md, 0, 0);
  endtask

  task automatic clear();
    step(1, 0, 0, 0, 0, 1, 0);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rmode;
    bit          rfrz;

    // Reset
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("rst_data", user_data_out, 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_cnt", 32'(sample_cnt), 32'h0);

    // Instantaneous: 3 + 5 appears two edges after being driven
    step(1, 1, 3, 5, 0, 0, 0);
    check("t1_early_valid", 32'(out_valid), 32'h0);
    idle(0);
    check("t1_data", user_data_out, 32'h8);
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_cnt", 32'(sample_cnt), 32'h1);
    check("t1_ovf", 32'(ovf), 32'h0);
    idle(0);
    check("t1_pulse_end", 32'(out_valid), 32'h0);

    // Accumulate: four back-to-back 0x10 + 0x01
    clear();
    for (int i = 0; i < 4; i++) step(1, 1, 32'h10, 32'h01, 1, 0, 0);
    idle(1);
    check("t2_data", user_data_out, 32'h44);
    check("t2_cnt", 32'(sample_cnt), 32'h4);

    // Reset mid-accumulation, then 1 + 1 in accumulate mode
    step(0, 0, 0, 0, 1, 0, 0);
    check("t6_data", user_data_out, 32'h0);
    check("t6_cnt", 32'(sample_cnt), 32'h0);
    step(1, 1, 1, 1, 1, 0, 0);
    idle(1);
    check("t6_after", user_data_out, 32'h2);

    // Freeze while output shows 0x22
    clear();
    step(1, 1, 32'h10, 32'h01, 1, 0, 0);
    step(1, 1, 32'h10, 32'h01, 1, 0, 0);
    idle(1);
    check("t3_pre", user_data_out, 32'h22);
    step(1, 1, 32'h10, 32'h01, 1, 0, 1);
    step(1, 1, 32'h10, 32'h01, 1, 0, 1);
    step(1, 0, 0, 0, 1, 0, 1);
    check("t3_held", user_data_out, 32'h22);
    check("t3_held_valid", 32'(out_valid), 32'h0);
    idle(1);
    check("t3_release_no_refresh", user_data_out, 32'h22);
    step(1, 1, 32'h10, 32'h01, 1, 0, 0);
    idle(1);
    check("t3_after", user_data_out, 32'h55);

    // Carry out of bit 31 in accumulate mode
    clear();
    step(1, 1, 32'h7FFF_FFF8, 32'h7FFF_FFF8, 0, 0, 0);
    step(1, 1, 32'h10, 32'h10, 0, 0, 0);
    check("t4_base", user_data_out, 32'hFFFF_FFF0);
    step(1, 1, 32'h1, 32'h0, 1, 0, 0);
    check("t4_ovf", 32'(ovf), 32'h1);
`ifdef SUM_A_B_SATURATE_EN
    check("t4_data", user_data_out, 32'hFFFF_FFFF);
    idle(1);
    check("t4_pinned", user_data_out, 32'hFFFF_FFFF);
`else
    check("t4_data", user_data_out, 32'h0000_0010);
    idle(1);
    check("t4_wrap_next", user_data_out, 32'h0000_0011);
`endif

    // clr while two samples are in flight
    step(1, 1, 32'h5, 32'h6, 0, 0, 0);
    step(1, 1, 32'h7, 32'h8, 0, 1, 0);
    check("t5_data", user_data_out, 32'h0);
    check("t5_cnt", 32'(sample_cnt), 32'h0);
    check("t5_ovf", 32'(ovf), 32'h0);
    check("t5_state", 32'(out_state), 32'h0);
    idle(0);
    check("t5_no_valid", 32'(out_valid), 32'h0);
    idle(0);

    // Counter saturation
    for (int i = 0; i < CNT_MAX + 5; i++) step(1, 1, i, 1, 0, 0, 0);
    idle(0);
    check("cnt_sat", 32'(sample_cnt), 32'(CNT_MAX));

    // Randomized traffic
    rmode = 0;
    rfrz  = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) rmode = ~rmode;
      if ($urandom_range(0, 9) == 0) rfrz = ~rfrz;
      if ($urandom_range(0, 3) == 0) begin
        ra = $urandom_range(0, 255);
        rb = $urandom_range(0, 255);
      end else begin
        ra = $urandom;
        rb = $urandom;
      end
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), ra, rb,
           rmode, ($urandom_range(0, 59) == 0), rfrz);
    end
    for (int i = 0; i < 3; i++) idle(rmode);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
